// File: rtl/uart_txn_arbiter.sv
// Round-robin request/response scheduler sharing one 64-bit UART word channel.
// One transaction in flight: grant, forward command, await reply or timeout, return reply.
module uart_txn_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4000000,
  parameter int unsigned IDW            = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ*64-1:0]  req_tdata,
  input  logic [N_REQ-1:0]     req_tvalid,
  output logic [N_REQ-1:0]     req_tready,
  output logic [63:0]          rsp_tdata,
  output logic                 rsp_terr,
  output logic [N_REQ-1:0]     rsp_tvalid,
  input  logic [N_REQ-1:0]     rsp_tready,
  output logic [63:0]          u_tx_tdata,
  output logic                 u_tx_tvalid,
  input  logic                 u_tx_tready,
  input  logic [63:0]          u_rx_tdata,
  input  logic                 u_rx_tvalid,
  output logic                 u_rx_tready,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic [15:0]          drop_count
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, RESP} state_t;

  localparam logic [31:0]    TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [IDW-1:0] LAST_INDEX = IDW'(N_REQ - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [31:0]    timer;
  logic [63:0]    rsp_buf;
  logic           rsp_err;
  logic [63:0]    req_word [N_REQ];
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic           tx_fire;
  logic           rx_fire;
  logic           timeout_hit;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req_word[i] = req_tdata[64*i +: 64];
    end
  end

  // Rotating priority: the candidate right after last_grant is checked first.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDW'((32'(last_grant) + k) % N_REQ);
      if (!win_found && req_tvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign tx_fire     = (state == SEND) && req_tvalid[grant_id] && u_tx_tready;
  assign rx_fire     = u_rx_tvalid && u_rx_tready;
  assign timeout_hit = (timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_found) state_nxt = SEND;
      SEND: if (tx_fire) state_nxt = WAIT;
      WAIT: if (u_rx_tvalid || timeout_hit) state_nxt = RESP;
      RESP: if (rsp_tready[grant_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_tready  = '0;
    rsp_tvalid  = '0;
    u_tx_tvalid = 1'b0;
    u_rx_tready = 1'b1;
    case (state)
      SEND: begin
        u_tx_tvalid          = req_tvalid[grant_id];
        req_tready[grant_id] = u_tx_tready;
      end
      RESP: begin
        rsp_tvalid[grant_id] = 1'b1;
        u_rx_tready          = 1'b0;
      end
      default: ;
    endcase
  end

  assign u_tx_tdata = req_word[grant_id];
  assign rsp_tdata  = rsp_buf;
  assign rsp_terr   = rsp_err;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= LAST_INDEX;
      last_grant <= LAST_INDEX;
      timer      <= '0;
      rsp_buf    <= '0;
      rsp_err    <= 1'b0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: if (win_found) grant_id <= win_idx;
        SEND: if (tx_fire) timer <= '0;
        WAIT: begin
          timer <= timer + 32'd1;
          if (u_rx_tvalid) begin
            rsp_buf <= u_rx_tdata;
            rsp_err <= 1'b0;
          end else if (timeout_hit) begin
            rsp_buf <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESP: if (rsp_tready[grant_id]) last_grant <= grant_id;
        default: ;
      endcase
      // Replies outside WAIT (late, unsolicited, or for an abandoned command) are discarded.
      if (rx_fire && (state != WAIT) && (drop_count != '1))
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_uart_txn_arbiter.sv
// Self-checking bench for uart_txn_arbiter: directed scenarios plus randomized
// transactions scored against a round-robin reference model.
module tb_uart_txn_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*64-1:0] req_tdata;
  logic [N-1:0]   req_tvalid;
  logic [N-1:0]   req_tready;
  logic [63:0]    rsp_tdata;
  logic           rsp_terr;
  logic [N-1:0]   rsp_tvalid;
  logic [N-1:0]   rsp_tready;
  logic [63:0]    u_tx_tdata;
  logic           u_tx_tvalid;
  logic           u_tx_tready;
  logic [63:0]    u_rx_tdata;
  logic           u_rx_tvalid;
  logic           u_rx_tready;
  logic           busy;
  logic [1:0]     grant_id;
  logic [15:0]    drop_count;

  int tests = 0;
  int fails = 0;
  int model_last;
  int model_drops;

  uart_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .rsp_tdata(rsp_tdata), .rsp_terr(rsp_terr), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .u_tx_tdata(u_tx_tdata), .u_tx_tvalid(u_tx_tvalid), .u_tx_tready(u_tx_tready),
    .u_rx_tdata(u_rx_tdata), .u_rx_tvalid(u_rx_tvalid), .u_rx_tready(u_rx_tready),
    .busy(busy), .grant_id(grant_id), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: first valid requester after the last one served, wrapping.
  function automatic int rr_pick(int last, logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int sat_drops(int d);
    return (d > 65535) ? 65535 : d;
  endfunction

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (u_tx_tvalid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (grant_id !== 2'd3) begin fails++; $display("FAIL reset_grant: got %0d expected 3", grant_id); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    tests++; if (rsp_tvalid !== 4'b0000) begin fails++; $display("FAIL reset_rsp_tvalid: got %b expected 0000", rsp_tvalid); end
    tests++; if (req_tready !== 4'b0000) begin fails++; $display("FAIL reset_req_tready: got %b expected 0000", req_tready); end
    tests++; if (u_tx_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", u_tx_tvalid); end
    tests++; if (u_rx_tready !== 1'b1) begin fails++; $display("FAIL reset_rx_ready: got %b expected 1", u_rx_tready); end
    tests++; if (rsp_terr !== 1'b0) begin fails++; $display("FAIL reset_terr: got %b expected 0", rsp_terr); end
    tests++; if (rsp_tdata !== 64'd0) begin fails++; $display("FAIL reset_rsp_tdata: got %h expected 0", rsp_tdata); end
    rst = 1'b0;
    model_last  = N - 1;
    model_drops = 0;
  endtask

  task automatic test_single_echo;
    req_tdata[64*2 +: 64] = 64'h0123_4567_89AB_CDEF;
    req_tvalid  = 4'b0100;
    u_tx_tready = 1'b1;
    @(negedge clk);
    tests++; if (u_tx_tvalid !== 1'b1) begin fails++; $display("FAIL echo_tx_latency: got %b expected 1", u_tx_tvalid); end
    tests++; if (u_tx_tdata !== 64'h0123_4567_89AB_CDEF) begin fails++; $display("FAIL echo_tx_data: got %h expected 0123456789abcdef", u_tx_tdata); end
    tests++; if (grant_id !== 2'd2) begin fails++; $display("FAIL echo_grant: got %0d expected 2", grant_id); end
    tests++; if (req_tready !== 4'b0100) begin fails++; $display("FAIL echo_req_tready: got %b expected 0100", req_tready); end
    @(negedge clk);
    req_tvalid = 4'b0000;
    tests++; if (u_tx_tvalid !== 1'b0) begin fails++; $display("FAIL echo_tx_once: got %b expected 0", u_tx_tvalid); end
    repeat (49) @(negedge clk);
    u_rx_tdata  = 64'hFEDC_BA98_7654_3210;
    u_rx_tvalid = 1'b1;
    @(negedge clk);
    u_rx_tvalid = 1'b0;
    tests++; if (rsp_tvalid !== 4'b0100) begin fails++; $display("FAIL echo_rsp_tvalid: got %b expected 0100", rsp_tvalid); end
    tests++; if (rsp_tdata !== 64'hFEDC_BA98_7654_3210) begin fails++; $display("FAIL echo_rsp_tdata: got %h expected fedcba9876543210", rsp_tdata); end
    tests++; if (rsp_terr !== 1'b0) begin fails++; $display("FAIL echo_rsp_terr: got %b expected 0", rsp_terr); end
    rsp_tready = 4'b0100;
    @(negedge clk);
    rsp_tready = 4'b0000;
    model_last = 2;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL echo_release: busy %b expected 0", busy); end
  endtask

  task automatic test_round_robin;
    bit ok;
    int exp;
    int order [6] = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < N; i++) req_tdata[64*i +: 64] = 64'hA000_0000_0000_0000 | 64'(i);
    req_tvalid  = 4'b1111;
    u_tx_tready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      exp = rr_pick(model_last, 4'b1111);
      wait_tx(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rr_wait_tx[%0d]: no command within bound", t); return; end
      tests++; if (grant_id !== 2'(exp)) begin fails++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", t, grant_id, exp); end
      tests++; if (grant_id !== 2'(order[t])) begin fails++; $display("FAIL rr_order[%0d]: got %0d expected %0d", t, grant_id, order[t]); end
      tests++; if (u_tx_tdata !== (64'hA000_0000_0000_0000 | 64'(exp))) begin fails++; $display("FAIL rr_tx_data[%0d]: got %h", t, u_tx_tdata); end
      @(negedge clk);
      u_rx_tdata  = 64'(100 + t);
      u_rx_tvalid = 1'b1;
      @(negedge clk);
      u_rx_tvalid = 1'b0;
      tests++; if (rsp_tvalid !== 4'(1 << exp)) begin fails++; $display("FAIL rr_rsp_tvalid[%0d]: got %b expected %b", t, rsp_tvalid, 4'(1 << exp)); end
      tests++; if (rsp_tdata !== 64'(100 + t)) begin fails++; $display("FAIL rr_rsp_tdata[%0d]: got %0d expected %0d", t, rsp_tdata, 100 + t); end
      rsp_tready = 4'(1 << exp);
      @(negedge clk);
      rsp_tready = 4'b0000;
      model_last = exp;
    end
    req_tvalid = 4'b0000;
  endtask

  task automatic test_timeout;
    bit ok;
    int cnt;
    req_tdata[64*1 +: 64] = 64'h1111_2222_3333_4444;
    req_tvalid  = 4'b0010;
    u_tx_tready = 1'b1;
    wait_tx(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL to_wait_tx: no command within bound"); return; end
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      req_tvalid = 4'b0000;
      cnt++;
      if (rsp_tvalid !== 4'b0000) break;
    end
    tests++; if (cnt !== TO + 1) begin fails++; $display("FAIL to_latency: got %0d cycles expected %0d", cnt, TO + 1); end
    tests++; if (rsp_tvalid !== 4'b0010) begin fails++; $display("FAIL to_rsp_tvalid: got %b expected 0010", rsp_tvalid); end
    tests++; if (rsp_tdata !== 64'd0) begin fails++; $display("FAIL to_rsp_tdata: got %h expected 0", rsp_tdata); end
    tests++; if (rsp_terr !== 1'b1) begin fails++; $display("FAIL to_rsp_terr: got %b expected 1", rsp_terr); end
    rsp_tready = 4'b0010;
    @(negedge clk);
    rsp_tready = 4'b0000;
    model_last = 1;
    repeat (19) @(negedge clk);
    u_rx_tdata  = 64'hDEAD_BEEF;
    u_rx_tvalid = 1'b1;
    @(negedge clk);
    u_rx_tvalid = 1'b0;
    model_drops = sat_drops(model_drops + 1);
    tests++; if (drop_count !== 16'(model_drops)) begin fails++; $display("FAIL to_late_drop: got %0d expected %0d", drop_count, model_drops); end
  endtask

  task automatic test_backpressure;
    bit ok;
    req_tdata[64*3 +: 64] = 64'h3333_CAFE_0000_0003;
    req_tvalid  = 4'b1000;
    u_tx_tready = 1'b0;
    wait_tx(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_wait_tx: no command within bound"); return; end
    for (int i = 0; i < 30; i++) begin
      tests++; if (req_tready !== 4'b0000) begin fails++; $display("FAIL bp_tx_ready[%0d]: got %b expected 0000", i, req_tready); end
      tests++; if (busy !== 1'b1 || u_tx_tvalid !== 1'b1) begin fails++; $display("FAIL bp_tx_hold[%0d]: busy %b valid %b expected 1 1", i, busy, u_tx_tvalid); end
      tests++; if (u_tx_tdata !== 64'h3333_CAFE_0000_0003) begin fails++; $display("FAIL bp_tx_data[%0d]: got %h", i, u_tx_tdata); end
      @(negedge clk);
    end
    u_tx_tready = 1'b1;
    #1;
    tests++; if (req_tready !== 4'b1000) begin fails++; $display("FAIL bp_tx_passthru: got %b expected 1000", req_tready); end
    @(negedge clk);
    req_tvalid  = 4'b0000;
    u_rx_tdata  = 64'h5555_6666_7777_8888;
    u_rx_tvalid = 1'b1;
    @(negedge clk);
    u_rx_tdata = 64'h9999_9999_9999_9999;
    for (int i = 0; i < 40; i++) begin
      tests++; if (rsp_tvalid !== 4'b1000) begin fails++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 1000", i, rsp_tvalid); end
      tests++; if (rsp_tdata !== 64'h5555_6666_7777_8888) begin fails++; $display("FAIL bp_rsp_data[%0d]: got %h", i, rsp_tdata); end
      tests++; if (u_rx_tready !== 1'b0) begin fails++; $display("FAIL bp_rx_ready[%0d]: got %b expected 0", i, u_rx_tready); end
      @(negedge clk);
    end
    u_rx_tvalid = 1'b0;
    tests++; if (drop_count !== 16'(model_drops)) begin fails++; $display("FAIL bp_no_drop: got %0d expected %0d", drop_count, model_drops); end
    rsp_tready = 4'b1000;
    @(negedge clk);
    rsp_tready = 4'b0000;
    model_last = 3;
  endtask

  task automatic test_random;
    bit ok;
    int exp;
    int dly;
    logic [N-1:0] mask;
    logic [63:0]  words [N];
    logic [63:0]  reply;
    mask = '0;
    u_tx_tready = 1'b1;
    for (int t = 0; t < 25; t++) begin
      // Newly raised requesters get fresh words; held ones keep theirs.
      for (int i = 0; i < N; i++) begin
        if (!mask[i] && ($urandom_range(0, 1) == 1)) begin
          mask[i]  = 1'b1;
          words[i] = {$urandom, $urandom};
        end
      end
      if (mask == '0) begin
        mask[0]  = 1'b1;
        words[0] = {$urandom, $urandom};
      end
      for (int i = 0; i < N; i++) req_tdata[64*i +: 64] = words[i];
      req_tvalid = mask;
      exp = rr_pick(model_last, mask);
      wait_tx(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL rnd_wait_tx[%0d]: no command within bound", t); return; end
      tests++; if (grant_id !== 2'(exp)) begin fails++; $display("FAIL rnd_grant[%0d]: got %0d expected %0d mask %b", t, grant_id, exp, mask); end
      tests++; if (u_tx_tdata !== words[exp]) begin fails++; $display("FAIL rnd_tx_data[%0d]: got %h expected %h", t, u_tx_tdata, words[exp]); end
      @(negedge clk);
      mask[exp]  = 1'b0;
      req_tvalid = mask;
      dly = $urandom_range(0, 20);
      repeat (dly) @(negedge clk);
      reply       = {$urandom, $urandom};
      u_rx_tdata  = reply;
      u_rx_tvalid = 1'b1;
      @(negedge clk);
      u_rx_tvalid = 1'b0;
      tests++; if (rsp_tvalid !== 4'(1 << exp)) begin fails++; $display("FAIL rnd_rsp_tvalid[%0d]: got %b expected %b", t, rsp_tvalid, 4'(1 << exp)); end
      tests++; if (rsp_tdata !== reply || rsp_terr !== 1'b0) begin fails++; $display("FAIL rnd_rsp[%0d]: got %h err %b expected %h err 0", t, rsp_tdata, rsp_terr, reply); end
      dly = $urandom_range(0, 3);
      repeat (dly) @(negedge clk);
      rsp_tready = 4'(1 << exp);
      @(negedge clk);
      rsp_tready = 4'b0000;
      model_last = exp;
    end
    req_tvalid = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_saturate;
    u_rx_tdata  = 64'h0BAD;
    u_rx_tvalid = 1'b1;
    @(negedge clk);
    u_rx_tvalid = 1'b0;
    model_drops = sat_drops(model_drops + 1);
    tests++; if (drop_count !== 16'(model_drops)) begin fails++; $display("FAIL sat_idle_drop: got %0d expected %0d", drop_count, model_drops); end
    u_rx_tvalid = 1'b1;
    repeat (70000) @(negedge clk);
    u_rx_tvalid = 1'b0;
    model_drops = sat_drops(model_drops + 70000);
    tests++; if (drop_count !== 16'(model_drops)) begin fails++; $display("FAIL sat_value: got %h expected %h", drop_count, model_drops); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL sat_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    for (int i = 0; i < N; i++) req_tdata[64*i +: 64] = 64'hBEEF_0000_0000_0000 | 64'(i);
    req_tvalid  = 4'b1111;
    u_tx_tready = 1'b1;
    wait_tx(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rm_wait_tx: no command within bound"); return; end
    @(negedge clk);
    repeat (5) @(negedge clk);
    tests++; if (busy !== 1'b1 || rsp_tvalid !== 4'b0000) begin fails++; $display("FAIL rm_in_wait: busy %b rsp %b expected 1 0000", busy, rsp_tvalid); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last  = N - 1;
    model_drops = 0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b expected 0", busy); end
    tests++; if (rsp_tvalid !== 4'b0000) begin fails++; $display("FAIL rm_rsp_tvalid: got %b expected 0000", rsp_tvalid); end
    tests++; if (drop_count !== 16'd0) begin fails++; $display("FAIL rm_drop_clear: got %0d expected 0", drop_count); end
    u_rx_tdata  = 64'hABAD_0ED0;
    u_rx_tvalid = 1'b1;
    @(negedge clk);
    u_rx_tvalid = 1'b0;
    model_drops = sat_drops(model_drops + 1);
    tests++; if (drop_count !== 16'(model_drops)) begin fails++; $display("FAIL rm_late_drop: got %0d expected %0d", drop_count, model_drops); end
    tests++; if (u_tx_tvalid !== 1'b1 || grant_id !== 2'(rr_pick(model_last, 4'b1111))) begin fails++; $display("FAIL rm_regrant: valid %b grant %0d expected 1 0", u_tx_tvalid, grant_id); end
    @(negedge clk);
    req_tvalid  = 4'b0000;
    u_rx_tdata  = 64'h0;
    u_rx_tvalid = 1'b1;
    @(negedge clk);
    u_rx_tvalid = 1'b0;
    rsp_tready  = 4'b0001;
    @(negedge clk);
    rsp_tready = 4'b0000;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_cleanup: busy %b expected 0", busy); end
  endtask

  initial begin
    rst         = 1'b1;
    req_tdata   = '0;
    req_tvalid  = '0;
    rsp_tready  = '0;
    u_tx_tready = 1'b0;
    u_rx_tdata  = '0;
    u_rx_tvalid = 1'b0;
    test_reset;
    test_single_echo;
    test_reset;
    test_round_robin;
    test_timeout;
    test_backpressure;
    test_random;
    test_saturate;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
